// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_arbiter
// Brief    : Two-port round-robin arbiter in front of a single-port data
//            memory. Every access walks IDLE -> SETUP -> ACCESS -> RESP.
// Revision : 1.0
// ============================================================================
module data_mem_arbiter #(
    parameter int DATA_MEM_ADDR_WIDTH = 16,
    parameter int DATA_MEM_WIDTH      = 16,
    parameter int DATA_MEM_SIZE       = 1024
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           req0,
    input  logic                           req1,
    input  logic                           we0,
    input  logic                           we1,
    input  logic [DATA_MEM_ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_MEM_ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_MEM_WIDTH-1:0]      wdata0,
    input  logic [DATA_MEM_WIDTH-1:0]      wdata1,
    output logic                           ack0,
    output logic                           ack1,
    output logic [DATA_MEM_WIDTH-1:0]      rdata,
    output logic                           err,
    output logic                           busy,
    output logic [DATA_MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_MEM_WIDTH-1:0]      mem_data_in,
    output logic                           mem_write,
    input  logic [DATA_MEM_WIDTH-1:0]      mem_data_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    // One extra bit so a size of 2**DATA_MEM_ADDR_WIDTH still compares correctly.
    localparam logic [DATA_MEM_ADDR_WIDTH:0] c_mem_size = (DATA_MEM_ADDR_WIDTH+1)'(DATA_MEM_SIZE);

    state_t                         state_q, state_d;
    logic                           we_q, we_d;
    logic [DATA_MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_MEM_WIDTH-1:0]      wdata_q, wdata_d;
    logic [DATA_MEM_WIDTH-1:0]      rdata_q, rdata_d;
    logic                           port_q, port_d;
    logic                           last_q, last_d;
    logic                           err_q, err_d;
    logic                           grant;
    logic                           in_range;

    assign in_range = ({1'b0, addr_q} < c_mem_size);

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        port_d  = port_q;
        last_d  = last_q;
        err_d   = err_q;
        grant   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // On a tie the port that was not served last goes first.
                    grant   = (req0 && req1) ? ~last_q : req1;
                    port_d  = grant;
                    we_d    = grant ? we1    : we0;
                    addr_d  = grant ? addr1  : addr0;
                    wdata_d = grant ? wdata1 : wdata0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                rdata_d = (!we_q && in_range) ? mem_data_out : '0;
                err_d   = !in_range;
                state_d = RESP;
            end
            RESP: begin
                last_d  = port_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            port_q  <= 1'b0;
            last_q  <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            port_q  <= port_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    // Address/data come straight from the request latches, so they are stable
    // for the whole SETUP..RESP window around the write strobe.
    assign mem_addr    = addr_q;
    assign mem_data_in = wdata_q;
    assign mem_write   = (state_q == ACCESS) && we_q && in_range;
    assign busy        = (state_q != IDLE);
    assign ack0        = (state_q == RESP) && !port_q;
    assign ack1        = (state_q == RESP) &&  port_q;
    assign rdata       = rdata_q;
    assign err         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_arbiter
// Brief    : Directed self-checking bench for data_mem_arbiter with a
//            behavioural 1024-word memory attached.
// Revision : 1.0
// ============================================================================
module tb_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [15:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic        ack0, ack1, err, busy, mem_write;
    logic [15:0] rdata, mem_addr, mem_data_in, mem_data_out;

    logic [15:0] mem [0:1023];
    logic        mem_init_done = 1'b0;
    int          write_pulses = 0;
    int          errors = 0;
    int          checks = 0;

    data_mem_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0         (req0),
        .req1         (req1),
        .we0          (we0),
        .we1          (we1),
        .addr0        (addr0),
        .addr1        (addr1),
        .wdata0       (wdata0),
        .wdata1       (wdata1),
        .ack0         (ack0),
        .ack1         (ack1),
        .rdata        (rdata),
        .err          (err),
        .busy         (busy),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_write    (mem_write),
        .mem_data_out (mem_data_out)
    );

    always #5 clk = ~clk;

    assign mem_data_out = (mem_addr < 16'd1024) ? mem[mem_addr[9:0]] : 16'h0000;

    // Word 0 holds 16'h2BCD, every other word i holds 16'h1000 + i.
    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 16'h1000 + 16'(i);
            mem[0] <= 16'h2BCD;
            mem_init_done <= 1'b1;
        end else if (mem_write) begin
            mem[mem_addr[9:0]] <= mem_data_in;
        end
        if (mem_write) write_pulses <= write_pulses + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts at a negedge in IDLE; returns at the negedge inside RESP.
    task automatic issue(input bit p, input bit w, input logic [15:0] a, input logic [15:0] d);
        if (!p) begin
            req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
        end else begin
            req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d;
        end
        @(negedge clk);
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        int pulses_before;

        @(negedge clk);
        check("rst_ack0", ack0, 0);
        check("rst_ack1", ack1, 0);
        check("rst_err", err, 0);
        check("rst_rdata", rdata, 16'h0);
        check("rst_busy", busy, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_mem_addr", mem_addr, 16'h0);
        check("rst_mem_data_in", mem_data_in, 16'h0);
        rst_n = 1'b1;

        // Read of word 0 from port 0
        pulses_before = write_pulses;
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'd0;
        @(negedge clk);
        req0 = 1'b0;
        check("rd_setup_busy", busy, 1);
        check("rd_setup_ack0", ack0, 0);
        @(negedge clk);
        check("rd_access_ack0", ack0, 0);
        @(negedge clk);
        check("rd_resp_ack0", ack0, 1);
        check("rd_resp_ack1", ack1, 0);
        check("rd_resp_rdata", rdata, 16'h2BCD);
        check("rd_resp_err", err, 0);
        @(negedge clk);
        check("rd_idle_ack0", ack0, 0);
        check("rd_idle_busy", busy, 0);
        check("rd_idle_rdata_hold", rdata, 16'h2BCD);
        check("rd_no_write", write_pulses - pulses_before, 0);

        // Port 1 writes A5A5 to word 10, then reads it back
        pulses_before = write_pulses;
        req1 = 1'b1; we1 = 1'b1; addr1 = 16'd10; wdata1 = 16'hA5A5;
        @(negedge clk);
        req1 = 1'b0;
        check("wr_setup_addr", mem_addr, 16'd10);
        check("wr_setup_data", mem_data_in, 16'hA5A5);
        check("wr_setup_write", mem_write, 0);
        @(negedge clk);
        check("wr_access_write", mem_write, 1);
        check("wr_access_addr", mem_addr, 16'd10);
        @(negedge clk);
        check("wr_resp_ack1", ack1, 1);
        check("wr_resp_ack0", ack0, 0);
        check("wr_resp_err", err, 0);
        check("wr_resp_write", mem_write, 0);
        check("wr_resp_addr", mem_addr, 16'd10);
        @(negedge clk);
        check("wr_one_pulse", write_pulses - pulses_before, 1);
        issue(1'b1, 1'b0, 16'd10, 16'h0);
        check("wr_rb_ack1", ack1, 1);
        check("wr_rb_rdata", rdata, 16'hA5A5);
        @(negedge clk);

        // Out-of-range write, then word 0 still intact
        pulses_before = write_pulses;
        issue(1'b0, 1'b1, 16'd1024, 16'hFFFF);
        check("oor_wr_ack0", ack0, 1);
        check("oor_wr_err", err, 1);
        @(negedge clk);
        check("oor_wr_no_pulse", write_pulses - pulses_before, 0);
        check("oor_wr_err_hold", err, 1);
        issue(1'b0, 1'b0, 16'd0, 16'h0);
        check("oor_rb_rdata", rdata, 16'h2BCD);
        check("oor_rb_err", err, 0);
        @(negedge clk);

        // Out-of-range read and last legal word
        issue(1'b1, 1'b0, 16'd2000, 16'h0);
        check("oor_rd_ack1", ack1, 1);
        check("oor_rd_rdata", rdata, 16'h0);
        check("oor_rd_err", err, 1);
        @(negedge clk);
        issue(1'b0, 1'b0, 16'd1023, 16'h0);
        check("top_rd_rdata", rdata, 16'h13FF);
        check("top_rd_err", err, 0);
        @(negedge clk);

        // Both ports requesting continuously from reset release
        rst_n = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'd1;
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'd2;
        #1;
        check("cont_rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            repeat (3) @(negedge clk);
            check("cont_ack0", ack0, (i % 2 == 0) ? 1 : 0);
            check("cont_ack1", ack1, (i % 2 == 1) ? 1 : 0);
            check("cont_rdata", rdata, (i % 2 == 0) ? 16'h1001 : 16'h1002);
            @(negedge clk);
            check("cont_gap_acks", {ack0, ack1}, 2'b00);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);

        // Reset during ACCESS of a port-0 write
        pulses_before = write_pulses;
        req0 = 1'b1; we0 = 1'b1; addr0 = 16'd5; wdata0 = 16'hDEAD;
        @(negedge clk);
        req0 = 1'b0;
        @(negedge clk);
        check("rmid_access_write", mem_write, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rmid_write_drop", mem_write, 0);
        check("rmid_busy", busy, 0);
        check("rmid_ack0", ack0, 0);
        @(negedge clk);
        check("rmid_no_ack0", ack0, 0);
        check("rmid_no_pulse", write_pulses - pulses_before, 0);
        rst_n = 1'b1;
        issue(1'b1, 1'b0, 16'd5, 16'h0);
        check("rmid_p1_ack1", ack1, 1);
        check("rmid_p1_ack0", ack0, 0);
        check("rmid_p1_rdata", rdata, 16'h1005);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
